// File: rtl/sct_sequencer.sv
// sct_sequencer: main-control sequencer for the Sequence Control Tank (SCT).
// Alternates the machine between Stage 1 (order fetch, g12) and Stage 2
// (order execution, g13). It clears the SCT on start. After each order it
// either increments the SCT (INCR) or loads a transfer address into it (XFER).
//
// A free-running digit counter (0..MINOR_CYCLE-1) defines minor cycles.
// State changes only at the wrap, so every state begins at d0. All outputs are
// registered from the next state and the next digit, so they stay aligned
// with the digit output.
//
// Ports:
//   clk, reset_neg      machine clock / asynchronous active-low reset
//   start               Starter Unit pulse (accepted in IDLE and HALT only)
//   coincidence         Coincidence Unit pulse (accepted in STAGE1 only)
//   order_done          execution-complete pulse (accepted in STAGE2 only)
//   cond_transfer       level, captured with order_done
//   stop_order          level, captured with order_done (wins over cond_transfer)
//   g12, g13            Stage 1 / Stage 2 gates
//   sct_one             SCT increment pulse, at d0 of INCR only
//   sct_in_gate         admit order into SCT (XFER)
//   sct_clear_gate      SCT recirculation gate, low during XFER
//   reset_sct_neg       SCT reset, low in IDLE and CLEAR
//   digit, ev_d0        current digit position / digit==0 marker
//   halted              stopped by stop order or watchdog
//   timeout_err         watchdog fired, sticky until the next accepted start
//
// Optional feature: define SCT_SEQ_TIMEOUT_EN to enable the STAGE1 watchdog
// (TIMEOUT_MC minor cycles). Without it, timeout_err is held at 0.
module sct_sequencer #(
  parameter int MINOR_CYCLE = 18,
  parameter int TIMEOUT_MC  = 32
) (
  input  logic       clk,
  input  logic       reset_neg,
  input  logic       start,
  input  logic       coincidence,
  input  logic       order_done,
  input  logic       cond_transfer,
  input  logic       stop_order,
  output logic       g12,
  output logic       g13,
  output logic       sct_one,
  output logic       sct_in_gate,
  output logic       sct_clear_gate,
  output logic       reset_sct_neg,
  output logic [4:0] digit,
  output logic       ev_d0,
  output logic       halted,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_STAGE1, S_STAGE2, S_INCR, S_XFER, S_HALT
  } state_t;

  state_t     state, state_nx;
  logic [4:0] digit_nx;
  logic       wrap;
  logic       start_flag, coin_flag, done_flag;
  logic       start_ev, coin_ev, done_ev;
  logic       stop_q, xfer_q;
  logic       stop_sel, xfer_sel;
  logic       timeout_hit;

`ifdef SCT_SEQ_TIMEOUT_EN
  localparam int MC_W = $clog2(TIMEOUT_MC) + 1;
  logic [MC_W-1:0] mc_cnt;
`endif

  always_comb begin
    wrap     = (digit == 5'(MINOR_CYCLE - 1));
    digit_nx = wrap ? 5'd0 : digit + 5'd1;
    // An event counts if already latched or arriving on this very clk; this
    // lets a pulse at the last digit take effect at the immediately next d0.
    start_ev = start_flag | (start & ((state == S_IDLE) || (state == S_HALT)));
    coin_ev  = coin_flag  | (coincidence & (state == S_STAGE1));
    done_ev  = done_flag  | (order_done & (state == S_STAGE2));
    // Order attributes belong to the done pulse, not to the wrap instant.
    stop_sel = done_flag ? stop_q : stop_order;
    xfer_sel = done_flag ? xfer_q : cond_transfer;
    timeout_hit = 1'b0;
`ifdef SCT_SEQ_TIMEOUT_EN
    timeout_hit = (state == S_STAGE1) && !coin_ev &&
                  (mc_cnt == MC_W'(TIMEOUT_MC - 1));
`endif
    state_nx = state;
    if (wrap) begin
      case (state)
        S_IDLE:   if (start_ev) state_nx = S_CLEAR;
        S_CLEAR:  state_nx = S_STAGE1;
        S_STAGE1: begin
          if (coin_ev)          state_nx = S_STAGE2;
          else if (timeout_hit) state_nx = S_HALT;
        end
        S_STAGE2: begin
          if (done_ev) begin
            if (stop_sel)      state_nx = S_HALT;
            else if (xfer_sel) state_nx = S_XFER;
            else               state_nx = S_INCR;
          end
        end
        S_INCR, S_XFER: state_nx = S_STAGE1;
        S_HALT:   if (start_ev) state_nx = S_INCR;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_neg) begin
    if (!reset_neg) begin
      state          <= S_IDLE;
      digit          <= 5'd0;
      start_flag     <= 1'b0;
      coin_flag      <= 1'b0;
      done_flag      <= 1'b0;
      stop_q         <= 1'b0;
      xfer_q         <= 1'b0;
      g12            <= 1'b0;
      g13            <= 1'b0;
      sct_one        <= 1'b0;
      sct_in_gate    <= 1'b0;
      sct_clear_gate <= 1'b1;
      reset_sct_neg  <= 1'b0;
      ev_d0          <= 1'b1;
      halted         <= 1'b0;
      timeout_err    <= 1'b0;
`ifdef SCT_SEQ_TIMEOUT_EN
      mc_cnt         <= '0;
`endif
    end else begin
      state <= state_nx;
      digit <= digit_nx;
      if (state_nx != state) begin
        start_flag <= 1'b0;
        coin_flag  <= 1'b0;
        done_flag  <= 1'b0;
      end else begin
        start_flag <= start_ev;
        coin_flag  <= coin_ev;
        done_flag  <= done_ev;
      end
      // Capture order attributes on the first accepted done pulse only.
      if (!done_flag && order_done && (state == S_STAGE2)) begin
        stop_q <= stop_order;
        xfer_q <= cond_transfer;
      end
      g12            <= (state_nx == S_STAGE1);
      g13            <= (state_nx == S_STAGE2);
      sct_one        <= (state_nx == S_INCR) && (digit_nx == 5'd0);
      sct_in_gate    <= (state_nx == S_XFER);
      sct_clear_gate <= (state_nx != S_XFER);
      reset_sct_neg  <= !((state_nx == S_IDLE) || (state_nx == S_CLEAR));
      ev_d0          <= (digit_nx == 5'd0);
      halted         <= (state_nx == S_HALT);
`ifdef SCT_SEQ_TIMEOUT_EN
      // Counts completed STAGE1 minor cycles; zero on every STAGE1 entry.
      if ((state != S_STAGE1) || (state_nx != S_STAGE1)) mc_cnt <= '0;
      else if (wrap)                                     mc_cnt <= mc_cnt + 1'b1;
      if ((state == S_STAGE1) && (state_nx == S_HALT))
        timeout_err <= 1'b1;
      else if ((state == S_HALT && state_nx == S_INCR) ||
               (state == S_IDLE && state_nx == S_CLEAR))
        timeout_err <= 1'b0;
`else
      timeout_err <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_sct_sequencer.sv
// Directed bench for sct_sequencer: reset state, start/CLEAR timing, a table
// of per-minor-cycle events with the expected outputs at the following d0,
// and hand sequences for XFER length, reset mid-XFER and the STAGE1 watchdog.
module tb_sct_sequencer;
  localparam int MC  = 18;
  localparam int TMC = 4;

  // Output vector order: {g12,g13,sct_one,sct_in_gate,sct_clear_gate,reset_sct_neg,halted}
  localparam logic [6:0] E_S1   = 7'b1000110;
  localparam logic [6:0] E_S2   = 7'b0100110;
  localparam logic [6:0] E_INCR = 7'b0010110;
  localparam logic [6:0] E_XFER = 7'b0001010;
  localparam logic [6:0] E_HALT = 7'b0000111;

  logic       clk = 1'b0;
  logic       reset_neg = 1'b0;
  logic       start = 1'b0, coincidence = 1'b0, order_done = 1'b0;
  logic       cond_transfer = 1'b0, stop_order = 1'b0;
  logic       g12, g13, sct_one, sct_in_gate, sct_clear_gate, reset_sct_neg;
  logic [4:0] digit;
  logic       ev_d0, halted, timeout_err;
  logic [7:0] outs;

  assign outs = {g12, g13, sct_one, sct_in_gate, sct_clear_gate, reset_sct_neg, halted, ev_d0};

  sct_sequencer #(.MINOR_CYCLE(MC), .TIMEOUT_MC(TMC)) dut (
    .clk(clk), .reset_neg(reset_neg), .start(start), .coincidence(coincidence),
    .order_done(order_done), .cond_transfer(cond_transfer), .stop_order(stop_order),
    .g12(g12), .g13(g13), .sct_one(sct_one), .sct_in_gate(sct_in_gate),
    .sct_clear_gate(sct_clear_gate), .reset_sct_neg(reset_sct_neg),
    .digit(digit), .ev_d0(ev_d0), .halted(halted), .timeout_err(timeout_err)
  );

  // clock
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired (digit=%0d)", name, digit);
  endtask

  // drivers (all driving and sampling on the falling edge)
  task automatic wait_digit(input int k);
    int n = 0;
    while (digit != 5'(k) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) bound_fail("wait_digit");
  endtask

  task automatic wait_d0();
    int n = 0;
    while (digit != 5'd0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) bound_fail("wait_d0");
  endtask

  task automatic pulse(input logic s, input logic c, input logic d,
                       input logic ct, input logic so);
    start = s; coincidence = c; order_done = d; cond_transfer = ct; stop_order = so;
    @(negedge clk);
    start = 0; coincidence = 0; order_done = 0; cond_transfer = 0; stop_order = 0;
  endtask

  // start at digit 5 from IDLE: 13 clks to d0, 18 clks of CLEAR, then STAGE1
  task automatic start_and_clear(input string name);
    int  n;
    logic ok;
    wait_digit(5);
    pulse(1, 0, 0, 0, 0);
    n = 1;
    ok = 1;
    while (digit != 5'd0 && n < 64) begin
      if (g12 || reset_sct_neg) ok = 0;
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, n, MC - 5);
    check({name, "_idle_hold"}, ok, 1);
    ok = 1;
    for (int i = 0; i < MC; i++) begin
      if (reset_sct_neg || g12 || g13) ok = 0;
      @(negedge clk);
    end
    check({name, "_clear_len"}, ok, 1);
    check({name, "_stage1"}, {digit, outs}, {5'd0, E_S1, 1'b1});
  endtask

  typedef struct {
    logic st, co, dn, ct, so;
    int   k;
    logic [6:0] exp;
  } vec_t;

  vec_t tv[17];

  initial begin
    logic ok;
    tv[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  9, E_S2};
    tv[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  3, E_INCR};
    tv[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  5, E_S1};
    tv[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11, E_S1};
    tv[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  4, E_S1};
    tv[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 17, E_S2};
    tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  0, E_XFER};
    tv[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  8, E_S1};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  2, E_S1};
    tv[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  0, E_S2};
    tv[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12, E_HALT};
    tv[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  3, E_HALT};
    tv[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  6, E_INCR};
    tv[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  1, E_S1};
    tv[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 17, E_S2};
    tv[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 17, E_XFER};
    tv[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  4, E_S1};

    // reset block
    reset_neg = 0;
    repeat (3) @(negedge clk);
    check("reset_outs", {timeout_err, digit, outs}, {1'b0, 5'd0, 8'b00001001});
    reset_neg = 1;
    wait_digit(3);
    check("idle_outs", {timeout_err, outs}, {1'b0, 8'b00001000});

    start_and_clear("start1");

    // table of minor-cycle events; outputs checked at the next d0 and d1
    for (int i = 0; i < 17; i++) begin
      wait_digit(tv[i].k);
      pulse(tv[i].st, tv[i].co, tv[i].dn, tv[i].ct, tv[i].so);
      wait_d0();
      check($sformatf("vec%0d_d0", i), outs, {tv[i].exp, 1'b1});
      @(negedge clk);
      check($sformatf("vec%0d_d1_one", i), sct_one, 1'b0);
    end

    // XFER lasts exactly one minor cycle
    pulse(0, 1, 0, 0, 0);
    wait_d0();
    pulse(0, 0, 1, 1, 0);
    wait_d0();
    ok = 1;
    for (int i = 0; i < MC; i++) begin
      if (!sct_in_gate || sct_clear_gate || g12 || g13) ok = 0;
      @(negedge clk);
    end
    check("xfer_len", ok, 1);
    check("xfer_to_s1", outs, {E_S1, 1'b1});

    // reset in the middle of XFER
    pulse(0, 1, 0, 0, 0);
    wait_d0();
    pulse(0, 0, 1, 1, 0);
    wait_d0();
    wait_digit(7);
    check("xfer_mid", outs, {E_XFER, 1'b0});
    reset_neg = 0;
    #1;
    check("reset_mid_xfer", {timeout_err, digit, outs}, {1'b0, 5'd0, 8'b00001001});
    @(negedge clk);
    check("reset_hold", {digit, outs}, {5'd0, 8'b00001001});
    reset_neg = 1;
    start_and_clear("start2");

`ifdef SCT_SEQ_TIMEOUT_EN
    ok = 1;
    for (int i = 0; i < TMC * MC; i++) begin
      if (!g12 || halted || timeout_err) ok = 0;
      @(negedge clk);
    end
    check("tmo_wait", ok, 1);
    check("tmo_fire", {g12, halted, timeout_err}, 3'b011);
    pulse(1, 0, 0, 0, 0);
    wait_d0();
    check("tmo_resume", {sct_one, halted, timeout_err}, 3'b100);
`else
    ok = 1;
    for (int i = 0; i < 5 * MC; i++) begin
      if (!g12 || halted || timeout_err) ok = 0;
      @(negedge clk);
    end
    check("s1_waits", ok, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sct_sequencer.md
# sct_sequencer

Main-control sequencer that drives the Sequence Control Tank and alternates the machine between Stage 1 (order fetch) and Stage 2 (order execution). It keeps the minor-cycle digit count and clears the SCT on start. After each order it either increments the SCT by one or loads a conditional-transfer address into it. It sits in the control section between the Starter Unit, the Coincidence Unit, the order decoder and the SCT.

## Interface
- `MINOR_CYCLE`, 18: pulse intervals per minor cycle (clk periods).
- `TIMEOUT_MC`, 32: Stage 1 watchdog limit in minor cycles; used only with `SCT_SEQ_TIMEOUT_EN`.
- `clk`  in  1  machine clock, one pulse interval.
- `reset_neg`  in  1  asynchronous reset, active-low.
- `start`  in  1  Starter Unit button pulse, one clk wide.
- `coincidence`  in  1  Coincidence Unit match pulse; valid only while `g12`=1.
- `order_done`  in  1  execution-complete pulse; valid only while `g13`=1.
- `cond_transfer`  in  1  level: the current order is a conditional transfer whose condition is met; sampled with `order_done`.
- `stop_order`  in  1  level: the current order is a stop order; sampled with `order_done`.
- `g12`  out  1  Stage 1 gate.
- `g13`  out  1  Stage 2 gate.
- `sct_one`  out  1  increment pulse to the SCT.
- `sct_in_gate`  out  1  admits the order into the SCT.
- `sct_clear_gate`  out  1  SCT recirculation gate; driving it low clears the SCT.
- `reset_sct_neg`  out  1  SCT reset, active-low.
- `digit`  out  5  current digit position, 0..`MINOR_CYCLE`-1.
- `ev_d0`  out  1  high while `digit`=0.
- `halted`  out  1  machine stopped by a stop order or watchdog.
- `timeout_err`  out  1  watchdog fired; sticky until the next `start`.

## Operation
- Free-running digit counter, 0..`MINOR_CYCLE`-1, then wraps to 0. It runs in every state.
- All outputs are registered.
- State changes happen only at the wrap, so each new state begins at d0.
- `coincidence` and `order_done` pulses are latched into flags at any digit. A flag is acted on at the next wrap and is cleared when the state changes.
- States:
  - IDLE: `reset_sct_neg`=0; all gates inactive. A `start` pulse arms the transition to CLEAR.
  - CLEAR: `reset_sct_neg`=0 for exactly one minor cycle, flushing all 18 bits. Then STAGE1.
  - STAGE1: `g12`=1. When the coincidence flag is set, go to STAGE2.
  - STAGE2: `g13`=1. When the done flag is set, `stop_order` and `cond_transfer` are sampled together:
    - `stop_order`=1 → HALT.
    - otherwise `cond_transfer`=1 → XFER.
    - otherwise → INCR.
    - If both `stop_order` and `cond_transfer` are 1, `stop_order` wins.
  - INCR: `sct_one`=1 for one clk at d0 only; rest of the minor cycle idle. Then STAGE1.
  - XFER: for the whole minor cycle, `sct_clear_gate`=0 and `sct_in_gate`=1. Then STAGE1.
  - HALT: `halted`=1. A `start` pulse leads to INCR, which resumes at the next order.
- `start` in any state other than IDLE or HALT is ignored.
- `g12` and `g13` are never high together, and never high in IDLE, CLEAR, INCR, XFER or HALT.

## Timing
- Reset values:
  - outputs: `g12`=0, `g13`=0, `sct_one`=0, `sct_in_gate`=0, `sct_clear_gate`=1, `reset_sct_neg`=0, `digit`=0, `ev_d0`=1, `halted`=0, `timeout_err`=0.
  - state: IDLE.
- Reset asserted mid-operation: immediate return to the reset values. Latched flags are cleared.
- A `start` pulse arriving at any digit of a minor cycle causes CLEAR to begin at the following d0.
- CLEAR to STAGE1: exactly `MINOR_CYCLE` clks.
- Event to response: an event (`start`, `coincidence`, `order_done`) latched at digit k takes effect `MINOR_CYCLE`-k clks later.
- Event at digit `MINOR_CYCLE`-1: it takes effect at the immediately following d0.
- Pulse on the cycle where the state changes: the pulse is latched, not dropped.
- `sct_one` is coincident with `ev_d0`, aligned to the SCT least-significant digit.

## Configuration
- `SCT_SEQ_TIMEOUT_EN` defined:
  - STAGE1 counts minor cycles.
  - Reaching `TIMEOUT_MC` without coincidence sets `timeout_err`=1 and enters HALT.
  - The counter resets on each STAGE1 entry.
- `SCT_SEQ_TIMEOUT_EN` undefined: STAGE1 waits indefinitely and `timeout_err` is tied to 0.

## Test plan
- Reset, then `start` at digit 5 → CLEAR from the next d0 for 18 clks with `reset_sct_neg`=0; `g12`=1 from clk 18 after that d0.
- Stage cycle:
  - stimulus: `coincidence` at digit 9 of STAGE1, then `order_done` with `cond_transfer`=0.
  - response: `g13`=1 at the next d0; then one `sct_one` pulse, exactly at d0; `g12` returns one minor cycle later.
- `order_done` with `cond_transfer`=1 → one minor cycle with `sct_clear_gate`=0 and `sct_in_gate`=1 for 18 clks, then STAGE1.
- `order_done` with `stop_order`=1 and `cond_transfer`=1 → HALT with `halted`=1 and no SCT gate activity. `start` → INCR, then STAGE1.
- With `SCT_SEQ_TIMEOUT_EN` and `TIMEOUT_MC`=4: no `coincidence` → `timeout_err`=1 and `halted`=1 after 4×18 clks of STAGE1.
- Reset pulsed mid-XFER → all outputs return to their reset values immediately; `start` afterwards → normal CLEAR.
